// File: rtl/adder_tree_pipe.sv
// adder_tree_pipe: pipelined multi-operand adder tree with valid/ready flow control.
// Define ADDER_TREE_ACC_EN to add a post-tree group accumulator (ACC_EXT extra output bits, one extra stage).
module adder_tree_pipe #(
    parameter int INPUTS_NUM  = 6,
    parameter int IDATA_WIDTH = 32,
    parameter int SIGNED      = 0,
    parameter int REG_EVERY   = 1,
`ifdef ADDER_TREE_ACC_EN
    parameter int ACC_EXT     = 8,
`else
    localparam int ACC_EXT    = 0,
`endif
    localparam int STAGES_NUM  = (INPUTS_NUM > 1) ? $clog2(INPUTS_NUM) : 0,
    localparam int TREE_LAT    = (STAGES_NUM == 0) ? 1 : (STAGES_NUM + REG_EVERY - 1) / REG_EVERY,
    localparam int TREE_WIDTH  = IDATA_WIDTH + STAGES_NUM,
    localparam int ODATA_WIDTH = TREE_WIDTH + ACC_EXT
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [INPUTS_NUM*IDATA_WIDTH-1:0] idata,
    input  logic                              in_last,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [ODATA_WIDTH-1:0]            odata
);

    localparam int PAD_NUM = 1 << STAGES_NUM;

    logic                  en;
    logic [TREE_WIDTH-1:0] tree_sum;
    logic [TREE_LAT-1:0]   vld;

    // The whole pipe advances together; a stalled output freezes every stage.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Operands are extended to the final tree width at the leaves; since no
    // partial sum can overflow, this equals growing one bit per stage.
    for (genvar s = 0; s <= STAGES_NUM; s++) begin : g_stage
        localparam bit IS_REG = (s == STAGES_NUM) || ((s > 0) && ((s % REG_EVERY) == 0));

        for (genvar j = 0; j < (PAD_NUM >> s); j++) begin : g_node
            logic [TREE_WIDTH-1:0] comb_val;
            logic [TREE_WIDTH-1:0] val;

            if (s == 0) begin : g_leaf
                if (j < INPUTS_NUM) begin : g_op
                    if (SIGNED != 0) begin : g_sx
                        logic signed [IDATA_WIDTH-1:0] op_s;
                        logic signed [TREE_WIDTH-1:0]  op_x;
                        assign op_s     = idata[j*IDATA_WIDTH +: IDATA_WIDTH];
                        assign op_x     = op_s;
                        assign comb_val = op_x;
                    end else begin : g_zx
                        logic [IDATA_WIDTH-1:0] op_u;
                        assign op_u     = idata[j*IDATA_WIDTH +: IDATA_WIDTH];
                        assign comb_val = TREE_WIDTH'(op_u);
                    end
                end else begin : g_pad
                    assign comb_val = '0;
                end
            end else begin : g_add
                assign comb_val = g_stage[s-1].g_node[2*j].val + g_stage[s-1].g_node[2*j+1].val;
            end

            if (IS_REG) begin : g_reg
                logic [TREE_WIDTH-1:0] q;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        q <= '0;
                    end else if (en) begin
                        q <= comb_val;
                    end
                end
                assign val = q;
            end else begin : g_wire
                assign val = comb_val;
            end
        end
    end

    assign tree_sum = g_stage[STAGES_NUM].g_node[0].val;

    if (TREE_LAT > 1) begin : g_vsr
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld <= '0;
            end else if (en) begin
                vld <= {vld[TREE_LAT-2:0], in_valid};
            end
        end
    end else begin : g_vsr1
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld <= '0;
            end else if (en) begin
                vld <= in_valid;
            end
        end
    end

`ifdef ADDER_TREE_ACC_EN
    logic [TREE_LAT-1:0]    lst;
    logic [ODATA_WIDTH-1:0] sum_ext;
    logic [ODATA_WIDTH-1:0] acc;
    logic                   grp_first;
    logic                   tree_valid;
    logic                   tree_last;

    if (TREE_LAT > 1) begin : g_lsr
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lst <= '0;
            end else if (en) begin
                lst <= {lst[TREE_LAT-2:0], in_last};
            end
        end
    end else begin : g_lsr1
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lst <= '0;
            end else if (en) begin
                lst <= in_last;
            end
        end
    end

    if (SIGNED != 0) begin : g_acc_sx
        logic signed [TREE_WIDTH-1:0]  ts;
        logic signed [ODATA_WIDTH-1:0] tx;
        assign ts      = tree_sum;
        assign tx      = ts;
        assign sum_ext = tx;
    end else begin : g_acc_zx
        assign sum_ext = ODATA_WIDTH'(tree_sum);
    end

    assign tree_valid = vld[TREE_LAT-1];
    assign tree_last  = lst[TREE_LAT-1];

    // Only valid beats touch the accumulator; bubbles pass without effect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            grp_first <= 1'b1;
            out_valid <= 1'b0;
        end else if (en) begin
            out_valid <= tree_valid && tree_last;
            if (tree_valid) begin
                acc       <= grp_first ? sum_ext : acc + sum_ext;
                grp_first <= tree_last;
            end
        end
    end

    assign odata = acc;
`else
    logic unused_in_last;

    assign unused_in_last = in_last;
    assign out_valid      = vld[TREE_LAT-1];
    assign odata          = tree_sum;
`endif

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Directed self-checking bench for adder_tree_pipe (default and ADDER_TREE_ACC_EN builds).
module tb_adder_tree_pipe;

`ifdef ADDER_TREE_ACC_EN
    localparam int   XW    = 8;
    localparam int   XL    = 1;
    localparam logic LASTV = 1'b1;
`else
    localparam int   XW    = 0;
    localparam int   XL    = 0;
    localparam logic LASTV = 1'b0;
`endif
    localparam int O0 = 35 + XW;
    localparam int O1 = 11 + XW;
    localparam int O2 = 11 + XW;
    localparam int O4 = 8 + XW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          in_valid0, in_ready0, in_last0, out_valid0, out_ready0;
    logic [191:0]  idata0;
    logic [O0-1:0] odata0;

    logic          sw_valid, sw_ready, sw_last;
    logic          rdy1, rdy2, rdy3, rdy4;
    logic          ov1, ov2, ov3, ov4;
    logic [39:0]   idata1;
    logic [47:0]   idata2, idata3;
    logic [7:0]    idata4;
    logic [O1-1:0] odata1;
    logic [O2-1:0] odata2, odata3;
    logic [O4-1:0] odata4;

    adder_tree_pipe u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .idata(idata0),
        .in_last(in_last0), .out_valid(out_valid0), .out_ready(out_ready0), .odata(odata0)
    );
    adder_tree_pipe #(.INPUTS_NUM(5), .IDATA_WIDTH(8), .SIGNED(1), .REG_EVERY(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rdy1), .idata(idata1),
        .in_last(sw_last), .out_valid(ov1), .out_ready(sw_ready), .odata(odata1)
    );
    adder_tree_pipe #(.INPUTS_NUM(6), .IDATA_WIDTH(8), .SIGNED(0), .REG_EVERY(2)) u2 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rdy2), .idata(idata2),
        .in_last(sw_last), .out_valid(ov2), .out_ready(sw_ready), .odata(odata2)
    );
    adder_tree_pipe #(.INPUTS_NUM(6), .IDATA_WIDTH(8), .SIGNED(0), .REG_EVERY(3)) u3 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rdy3), .idata(idata3),
        .in_last(sw_last), .out_valid(ov3), .out_ready(sw_ready), .odata(odata3)
    );
    adder_tree_pipe #(.INPUTS_NUM(1), .IDATA_WIDTH(8), .SIGNED(0), .REG_EVERY(1)) u4 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rdy4), .idata(idata4),
        .in_last(sw_last), .out_valid(ov4), .out_ready(sw_ready), .odata(odata4)
    );

    int          vectors = 0;
    int          miscompares = 0;
    int          lat0;
    logic [63:0] got0;
    int          lat_s [1:4];
    logic [63:0] got_s [1:4];
    int          sent, rcvd, nb, nout;
    logic [O1-1:0] e1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [191:0] rep6(input logic [31:0] v);
        logic [191:0] r;
        for (int k = 0; k < 6; k++) r[k*32 +: 32] = v;
        return r;
    endfunction

    function automatic logic [191:0] seq6();
        logic [191:0] r;
        for (int k = 0; k < 6; k++) r[k*32 +: 32] = 32'(k + 1);
        return r;
    endfunction

    // One beat into u0 with out_ready held high; records cycles to out_valid and the result.
    task automatic run0(input logic [191:0] d);
        idata0     = d;
        in_valid0  = 1'b1;
        in_last0   = LASTV;
        out_ready0 = 1'b1;
        lat0       = 0;
        got0       = '0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            in_valid0 = 1'b0;
            if (out_valid0 && lat0 == 0) begin
                lat0 = c;
                got0 = 64'(odata0);
            end
        end
    endtask

    task automatic run_sweep();
        sw_valid = 1'b1;
        sw_last  = LASTV;
        for (int i = 1; i <= 4; i++) begin
            lat_s[i] = 0;
            got_s[i] = '0;
        end
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            sw_valid = 1'b0;
            if (ov1 && lat_s[1] == 0) begin lat_s[1] = c; got_s[1] = 64'(odata1); end
            if (ov2 && lat_s[2] == 0) begin lat_s[2] = c; got_s[2] = 64'(odata2); end
            if (ov3 && lat_s[3] == 0) begin lat_s[3] = c; got_s[3] = 64'(odata3); end
            if (ov4 && lat_s[4] == 0) begin lat_s[4] = c; got_s[4] = 64'(odata4); end
        end
    endtask

    initial begin
        rst        = 1'b1;
        in_valid0  = 1'b0;
        in_last0   = 1'b0;
        out_ready0 = 1'b1;
        idata0     = '0;
        sw_valid   = 1'b0;
        sw_ready   = 1'b1;
        sw_last    = 1'b0;
        idata1     = '0;
        idata2     = '0;
        idata3     = '0;
        idata4     = '0;

        #2;
        check("rst_out_valid", 64'(out_valid0), 64'(0));
        check("rst_odata", 64'(odata0), 64'(0));
        check("rst_in_ready", 64'(in_ready0), 64'(1));
        check("rst_in_ready_sweep", 64'({rdy1, rdy2, rdy3, rdy4}), 64'(4'hF));
        check("rst_ov_sweep", 64'({ov1, ov2, ov3, ov4}), 64'(0));
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;

        run0(seq6());
        check("lat_default", 64'(lat0), 64'(3 + XL));
        check("sum_1to6", got0, 64'd21);

        run0(rep6(32'hFFFF_FFFF));
        check("lat_all_ones", 64'(lat0), 64'(3 + XL));
        check("sum_all_ones", got0, 64'h5_FFFF_FFFA);

        idata1 = {5{8'h80}};
        idata2 = {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        idata3 = {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        idata4 = 8'hA5;
        run_sweep();
        e1 = O1'(-640);
        check("lat_signed", 64'(lat_s[1]), 64'(3 + XL));
        check("sum_neg640", got_s[1], 64'(e1));
        check("lat_reg_every2", 64'(lat_s[2]), 64'(2 + XL));
        check("sum_reg_every2", got_s[2], 64'd21);
        check("lat_reg_every3", 64'(lat_s[3]), 64'(1 + XL));
        check("sum_reg_every3", got_s[3], 64'd21);
        check("lat_single", 64'(lat_s[4]), 64'(1 + XL));
        check("single_operand", got_s[4], 64'h0A5);

        idata1 = {8'h00, 8'h00, 8'h00, 8'hFF, 8'h7F};
        run_sweep();
        check("sum_mix_126", got_s[1], 64'd126);

        // Backpressure: ten beats, out_ready pattern 1,0,0,1.
        sent = 0;
        rcvd = 0;
        for (int c = 0; c < 200 && rcvd < 10; c++) begin
            @(posedge clk); #1;
            out_ready0 = ((c % 4) == 0) || ((c % 4) == 3);
            in_valid0  = (sent < 10);
            idata0     = rep6(32'(sent + 1));
            in_last0   = LASTV;
            #3;
            if (out_ready0) check("bp_in_ready_open", 64'(in_ready0), 64'(1));
            else if (out_valid0) check("bp_in_ready_stall", 64'(in_ready0), 64'(0));
            if (out_valid0) check("bp_odata", 64'(odata0), 64'(6 * (rcvd + 1)));
            if (out_valid0 && out_ready0) rcvd++;
            if (in_valid0 && in_ready0) sent++;
        end
        check("bp_count", 64'(rcvd), 64'(10));
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            in_valid0  = 1'b0;
            out_ready0 = 1'b1;
            check("bp_no_extra", 64'(out_valid0), 64'(0));
        end

        // Reset with three beats held in the pipe.
        in_valid0  = 1'b1;
        out_ready0 = 1'b0;
        idata0     = rep6(32'd7);
        in_last0   = LASTV;
        repeat (3) @(posedge clk);
        #1;
        rst       = 1'b1;
        in_valid0 = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid0), 64'(0));
        check("midrst_odata", 64'(odata0), 64'(0));
        check("midrst_in_ready", 64'(in_ready0), 64'(1));
        @(posedge clk);
        @(posedge clk); #1;
        rst        = 1'b0;
        out_ready0 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check("midrst_no_stale", 64'(out_valid0), 64'(0));
        end
        run0(seq6());
        check("post_rst_lat", 64'(lat0), 64'(3 + XL));
        check("post_rst_sum", got0, 64'd21);

`ifdef ADDER_TREE_ACC_EN
        // Group of three beats then a one-beat group, back to back.
        idata0     = seq6();
        out_ready0 = 1'b1;
        in_valid0  = 1'b1;
        in_last0   = 1'b0;
        nb   = 0;
        nout = 0;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            if (out_valid0) begin
                if (nout == 0) check("acc_group1", 64'(odata0), 64'd63);
                else if (nout == 1) check("acc_group2", 64'(odata0), 64'd21);
                nout++;
            end
            if (in_valid0) nb++;
            in_valid0 = (nb < 4);
            in_last0  = (nb >= 2);
        end
        check("acc_out_count", 64'(nout), 64'(2));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adder_tree_pipe.md
Name: adder_tree_pipe

Overview:
Parametrised, pipelined successor to the combinational adder tree. Sums INPUTS_NUM operands, signed or unsigned, with a register slice inserted every REG_EVERY adder stages. A valid/ready handshake carries the data. Used in the floating-point datapath wherever multi-operand mantissa/partial-product sums need timing closure.

Parameters:
INPUTS_NUM, 6, number of operands; need not be a power of two; >=1
IDATA_WIDTH, 32, width of each operand
SIGNED, 0, 1 = operands two's-complement (sign-extended at every stage); 0 = zero-extended
REG_EVERY, 1, register slice after every REG_EVERY adder stages; >=1
STAGES_NUM (local), $clog2(INPUTS_NUM), number of adder stages
LAT (local), max(1, ceil(STAGES_NUM/REG_EVERY)), pipeline latency in enabled cycles
ODATA_WIDTH (local), IDATA_WIDTH+STAGES_NUM (+ACC_EXT when ADDER_TREE_ACC_EN), output width

Ports:
clk  in  1  clock, all flops rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  idata valid
in_ready  out  1  block accepts idata this cycle
idata  in  INPUTS_NUM*IDATA_WIDTH  packed operands; operand k is bits [k*IDATA_WIDTH +: IDATA_WIDTH]
in_last  in  1  last beat of an accumulation group; used only with ADDER_TREE_ACC_EN
out_valid  out  1  odata valid
out_ready  in  1  downstream accepts odata
odata  out  ODATA_WIDTH  sum

Behaviour:
- Tree: the operand count is padded to 2**STAGES_NUM with zero operands. Stage s adds pairs at width IDATA_WIDTH+s, extending each operand by 1 bit per SIGNED. A sum never overflows. Stage s output is registered iff s%REG_EVERY==0 or s==STAGES_NUM.
- INPUTS_NUM==1: odata is the extended operand, registered once; LAT=1.
- Pipeline enable: en = !out_valid | out_ready. in_ready = en, combinational. All data and valid registers load only when en. Bubbles are not squeezed.
- The valid shift register has LAT bits. Bit 0 loads in_valid & in_ready. out_valid is the last bit. Data registers load regardless of valid (when en).
- Latency: a beat accepted at cycle t appears at t+LAT if no stall occurs. A stall holds every stage, and odata stays stable while out_valid & !out_ready.
- Throughput: one beat/cycle when out_ready is held 1.
- Reset (async assert, synchronous release): all valid bits 0, so out_valid=0, odata=0, in_ready=1 after reset. Data registers also clear to 0. Reset mid-operation discards all in-flight beats; no partial result emerges.
- Simultaneous in_valid and out_ready with out_valid=1: the output pops and a new beat enters in the same cycle.
- in_valid=0 with en=1: a bubble enters and downstream stages still advance.

Optional Feature:
ADDER_TREE_ACC_EN defined:
- Adds a post-tree accumulator stage; LAT grows by 1.
- ODATA_WIDTH gains ACC_EXT, a parameter with default 8.
- The accumulator loads the tree sum on the first beat of a group and adds the sum on later beats. A group ends at a valid beat with in_last=1 (in_last travels in the pipe).
- out_valid pulses only for the last beat of a group, with the group total.
- The accumulator wraps modulo 2**ODATA_WIDTH.
- Reset clears the accumulator and the group state; the next beat starts a new group.
ADDER_TREE_ACC_EN undefined:
- No accumulator; in_last is ignored; every accepted beat produces one output.

Test Plan:
- Defaults (6x32, unsigned, REG_EVERY=1): operands 1,2,3,4,5,6, out_ready=1 -> odata=21 exactly 3 cycles after acceptance. All operands 32'hFFFFFFFF -> odata=35'h5_FFFFFFFA.
- SIGNED=1, IDATA_WIDTH=8, INPUTS_NUM=5: operands -128,-128,-128,-128,-128 -> odata=-640 (11'h580). Mix of 127,-1,0,0,0 -> odata=126.
- Backpressure: stream 10 beats (beat n = all operands n); out_ready toggles 1,0,0,1 repeating -> in-order sums 6n, none lost or duplicated. odata holds steady while stalled. in_ready tracks en.
- Latency sweep: REG_EVERY=1,2,3 with INPUTS_NUM=6 -> LAT=3,2,1. INPUTS_NUM=1 -> LAT=1 and odata=operand.
- Reset mid-stream: assert rst with 3 beats in flight -> out_valid=0 and odata=0 immediately. After release, no stale beat emerges and the next accepted beat is correct.
- ADDER_TREE_ACC_EN: 3 beats of operands 1..6 with in_last on beat 3 -> a single out_valid with odata=63. A back-to-back second group of 1 beat -> odata=21.
